fp16_mul_arbiter: RTL
=====================

# fp16_mul_arbiter

Shares one combinational `fp16_mul` instance (DWIDTH 16, EWIDTH 5, MWIDTH 10, BIAS 15) between NREQ requesters. Operands are registered at grant and the multiplier gets MUL_CYCLES clock cycles to settle as a multicycle path. Result and flags are then captured and returned over a valid/ready response channel tagged with the requester ID. The block sits between the FPU clients and the multiplier datapath and is the only driver of the multiplier's operand inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ
- MUL_CYCLES, 2, cycles allowed for the multiplier to settle (1..15)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*16  operand A, requester i at [16i+15:16i]
- req_b  in  NREQ*16  operand B, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  requester index of the response
- rsp_result  out  16  fp16 product
- rsp_exception  out  1  Exception flag from the multiplier
- rsp_overflow  out  1  Overflow flag from the multiplier
- rsp_underflow  out  1  Underflow flag from the multiplier
- busy  out  1  high in EXEC and RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - The round-robin arbiter selects grant g = first i with req_valid[i]=1, searching from pointer ptr upward modulo NREQ.
  - req_ready[g]=1 combinationally. All other req_ready bits are 0.
  - On the edge: latch req_a[g] and req_b[g] into the operand registers, latch g into the id register, set ptr <= (g+1) mod NREQ, load cnt <= MUL_CYCLES-1, and go to EXEC.
  - If no request is valid, stay in IDLE and leave ptr unchanged.
- **EXEC**
  - The operand registers drive the multiplier. All req_ready bits are 0.
  - cnt decrements each cycle.
  - In the cycle cnt==0: capture result and the three flags into the rsp registers, set rsp_valid <= 1, and go to RESP.
- **RESP**
  - rsp_* outputs hold steady while rsp_valid=1 and rsp_ready=0.
  - On the cycle with rsp_ready=1: clear rsp_valid and go to IDLE.
  - No new grant is made in the same cycle as the response handoff.
- Operand registers hold their values outside EXEC. The multiplier inputs change only on a grant edge.
- Flags pass through from the multiplier unmodified. The arbiter does no arithmetic.
- Requester behaviour requirement: a requester whose req_valid is high while it is not granted must hold req_a/req_b stable. Deasserting req_valid before it is granted is legal; such a request is simply never granted.

## Timing
- Reset (rstn low, asynchronous), all of the following are 0:
  - state=IDLE
  - ptr, cnt, operand registers, id register
  - rsp_valid, rsp_id, rsp_result, all flags
  - busy
- req_ready is 0 during reset.
- Latency, with the grant edge at T:
  - rsp_valid rises after edge T+MUL_CYCLES.
  - MUL_CYCLES=2 gives a response two cycles after acceptance.
- Throughput: minimum MUL_CYCLES+2 cycles per operation (grant, MUL_CYCLES EXEC cycles, one handoff cycle in RESP, return to IDLE).
- Fairness:
  - Requesters held continuously valid are served in strict rotation.
  - No requester waits more than NREQ-1 other grants.
- Back-pressure:
  - A stalled rsp_ready holds RESP indefinitely.
  - No requests are accepted during the stall.
  - rsp_* outputs do not change during the stall.
- Reset mid-operation (rstn low in EXEC or RESP): the transaction is dropped with no response. After release the FSM starts in IDLE with ptr=0.
- Simultaneous requests in IDLE: exactly one grant, chosen by ptr. Never two req_ready bits high at once.

## Test plan
- Single op: requester 0 sends a=0x5718, b=0xCB40, with rsp_ready=1.
  - Required: rsp_valid 2 cycles after acceptance, rsp_result=0xE66E, rsp_id=0.
- Second op: requester 2 sends a=0x475F, b=0x6A75.
  - Required: rsp_result=0x75F3, rsp_id=2, flags all 0.
- Round-robin: all 4 requesters valid from reset, each with a=0x3C00, b=0x3C00.
  - Required: grants in order 0,1,2,3,0; every result 0x3C00; ops spaced 4 cycles apart.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises, with requester 1 also valid.
  - Required: rsp_* stable, req_ready=0 throughout; requester 1 is granted one cycle after rsp_ready rises.
- Overflow: a=0x7BFF, b=0x7BFF.
  - Required: rsp_overflow=1, and rsp_result equals the multiplier's output for those operands.
- Reset mid-EXEC: assert rstn=0 one cycle after a grant.
  - Required: all outputs 0 immediately, no rsp_valid after release, next grant comes from a search starting at ptr=0.

Source files
------------

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin arbiter sharing one combinational fp16
// multiplier between NREQ requesters, plus the multiplier itself.
//
// fp16_mul ports:
//   a, b        operands (IEEE half precision; subnormal inputs read as zero)
//   result      rounded product (round to nearest even)
//   exception   an operand is Inf or NaN
//   overflow    finite product too large; result is signed Inf
//   underflow   nonzero product too small for a normal; result is signed zero
//
// fp16_mul_arbiter ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot or 0)
//   req_a, req_b               packed operands, requester i at [16i+15:16i]
//   rsp_valid/rsp_ready        response handshake
//   rsp_id                     index of the requester the response belongs to
//   rsp_result                 product
//   rsp_exception/overflow/underflow  multiplier flags, passed through
//   busy                       high while an operation is in EXEC or RESP

module fp16_mul #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned EWIDTH = 5,
  parameter int unsigned MWIDTH = 10,
  parameter int unsigned BIAS   = 15
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] result,
  output logic              exception,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned      PW   = 2 * (MWIDTH + 1);
  localparam logic [EWIDTH-1:0] EMAX = '1;

  logic              sa, sb, sr;
  logic [EWIDTH-1:0] ea, eb;
  logic [MWIDTH-1:0] ma, mb;
  logic              a_zero, b_zero, a_spec, b_spec, a_nan, b_nan;
  logic [PW-1:0]     prod;
  logic [MWIDTH-1:0] mant;
  logic              inc, guard, sticky, rnd;
  logic [MWIDTH:0]   mant_r;
  int                e;

  always_comb begin
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    sr     = sa ^ sb;
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_spec = (ea == EMAX);
    b_spec = (eb == EMAX);
    a_nan  = a_spec & (|ma);
    b_nan  = b_spec & (|mb);

    prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
    // Product of two 1.x significands is in [1,4); the top bit picks the
    // normalisation shift and which bits become guard/sticky.
    inc = prod[PW-1];
    if (inc) begin
      mant   = prod[PW-2 -: MWIDTH];
      guard  = prod[PW-2-MWIDTH];
      sticky = |prod[PW-3-MWIDTH:0];
    end else begin
      mant   = prod[PW-3 -: MWIDTH];
      guard  = prod[PW-3-MWIDTH];
      sticky = |prod[PW-4-MWIDTH:0];
    end
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{MWIDTH{1'b0}}, rnd};
    // A rounding carry leaves mant_r[MWIDTH-1:0] at zero and bumps the exponent.
    e = int'(ea) + int'(eb) - int'(BIAS) + int'(inc) + int'(mant_r[MWIDTH]);

    result    = '0;
    exception = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (a_spec | b_spec) begin
      exception = 1'b1;
      if (a_nan | b_nan | (a_spec & b_zero) | (b_spec & a_zero))
        result = {1'b0, EMAX, 1'b1, {(MWIDTH-1){1'b0}}};
      else
        result = {sr, EMAX, {MWIDTH{1'b0}}};
    end else if (a_zero | b_zero) begin
      result = {sr, {(DWIDTH-1){1'b0}}};
    end else if (e >= int'(EMAX)) begin
      overflow = 1'b1;
      result   = {sr, EMAX, {MWIDTH{1'b0}}};
    end else if (e <= 0) begin
      underflow = 1'b1;
      result    = {sr, {(DWIDTH-1){1'b0}}};
    end else begin
      result = {sr, e[EWIDTH-1:0], mant_r[MWIDTH-1:0]};
    end
  end

endmodule

module fp16_mul_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned IDW        = 2,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_result,
  output logic               rsp_exception,
  output logic               rsp_overflow,
  output logic               rsp_underflow,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr, id_q, gnt;
  logic [3:0]      cnt;
  logic [15:0]     op_a, op_b, sel_a, sel_b, mul_res;
  logic            mul_exc, mul_ovf, mul_unf;
  logic [NREQ-1:0] rot;
  logic            found;

  // rot[k] is the valid of requester (ptr+k) mod NREQ, so the first set bit
  // of rot is the round-robin winner.
  always_comb begin
    rot   = '0;
    found = 1'b0;
    gnt   = '0;
    for (int unsigned k = 0; k < NREQ; k++)
      for (int unsigned j = 0; j < NREQ; j++)
        if (j == (32'(ptr) + k) % NREQ) rot[k] = req_valid[j];
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        gnt   = IDW'((32'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt == IDW'(k)) begin
        sel_a        = req_a[16*k +: 16];
        sel_b        = req_b[16*k +: 16];
        req_ready[k] = rstn && (state == IDLE) && found;
      end
    end
  end

  fp16_mul #(
    .DWIDTH(16),
    .EWIDTH(5),
    .MWIDTH(10),
    .BIAS  (15)
  ) u_mul (
    .a        (op_a),
    .b        (op_b),
    .result   (mul_res),
    .exception(mul_exc),
    .overflow (mul_ovf),
    .underflow(mul_unf)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      op_a          <= '0;
      op_b          <= '0;
      id_q          <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_exception <= 1'b0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a  <= sel_a;
            op_b  <= sel_b;
            id_q  <= gnt;
            ptr   <= IDW'((32'(gnt) + 1) % NREQ);
            cnt   <= 4'(MUL_CYCLES - 1);
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Operands have been stable since the grant edge; the multiplier
          // output is only sampled once the settle budget has elapsed.
          if (cnt == '0) begin
            rsp_result    <= mul_res;
            rsp_exception <= mul_exc;
            rsp_overflow  <= mul_ovf;
            rsp_underflow <= mul_unf;
            rsp_id        <= id_q;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
